// File: rtl/tune_sequencer.sv
// Purpose: RAM-loaded multi-voice tune player; steps a writable song memory at a fixed tempo, one square wave per voice, mixed onto spkp/spkm.
// Latency: song memory read is registered (1 clk); it is addressed with the next step index so the note register always matches step_addr.
// Backpressure: none; writes are accepted every cycle in any state, start/stop are single-cycle pulses, stop beats start.
module tune_sequencer #(
    parameter int VOICES      = 2,
    parameter int ADDR_W      = 8,
    parameter int STEP_CYCLES = 4194304,
    parameter int GAP_CYCLES  = 262144,
    localparam int VW         = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              wr_en,
    input  logic [VW-1:0]     wr_voice,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [5:0]        wr_data,
    output logic [VOICES-1:0] spk,
    output logic              spkp,
    output logic              spkm,
    output logic              busy,
    output logic [ADDR_W-1:0] step_addr,
    output logic              done
);

    localparam int              SC_W      = $clog2(STEP_CYCLES);
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_CYCLES - 1);
    localparam logic [SC_W-1:0] GAP_END   = SC_W'(GAP_CYCLES);
    localparam logic [5:0]      CODE_END  = 6'd63;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t            state;
    logic [SC_W-1:0]   step_cnt;
    logic [ADDR_W-1:0] addr_nxt;

    logic [5:0] mem    [VOICES][2**ADDR_W];
    logic [5:0] note_q [VOICES];

    logic [8:0] div_val  [VOICES];
    logic [7:0] oct_rld  [VOICES];
    logic       audible  [VOICES];
    logic [8:0] note_cnt [VOICES];
    logic [7:0] oct_cnt  [VOICES];

    logic [VW-1:0] sel;

    logic step_wrap;
    logic last_step;
    logic song_end;
    logic go_idle;
    logic restart;
    logic advance;
    logic tone_run;
    logic gap_done;

    // Octave number of a note code (code / 12), codes above 62 clamp to 5.
    function automatic logic [2:0] oct_of(input logic [5:0] c);
        logic [2:0] o;
        o = 3'd0;
        if (c >= 6'd60)      o = 3'd5;
        else if (c >= 6'd48) o = 3'd4;
        else if (c >= 6'd36) o = 3'd3;
        else if (c >= 6'd24) o = 3'd2;
        else if (c >= 6'd12) o = 3'd1;
        return o;
    endfunction

    // Base-clock divider for each semitone, semitone 0 is A.
    function automatic logic [8:0] div_of(input logic [5:0] s);
        logic [8:0] d;
        case (s)
            6'd0:    d = 9'd511;
            6'd1:    d = 9'd482;
            6'd2:    d = 9'd455;
            6'd3:    d = 9'd430;
            6'd4:    d = 9'd405;
            6'd5:    d = 9'd383;
            6'd6:    d = 9'd361;
            6'd7:    d = 9'd341;
            6'd8:    d = 9'd322;
            6'd9:    d = 9'd303;
            6'd10:   d = 9'd286;
            6'd11:   d = 9'd270;
            default: d = 9'd511;
        endcase
        return d;
    endfunction

    // Per-voice note decode: divider, octave reload and whether the code makes sound.
    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            logic [2:0] oct;
            logic [5:0] semi;
            oct        = oct_of(note_q[v]);
            semi       = note_q[v] - ({3'b000, oct} * 6'd12);
            div_val[v] = div_of(semi);
            oct_rld[v] = 8'hFF >> oct;
            audible[v] = (note_q[v] != 6'd0) && (note_q[v] != CODE_END);
        end
    end

    // Sequencing decisions for this cycle; stop outranks start, start outranks song end.
    always_comb begin
        step_wrap = (step_cnt == STEP_LAST);
        last_step = (step_addr == {ADDR_W{1'b1}});
        song_end  = ((step_cnt == '0) && (note_q[0] == CODE_END)) || (step_wrap && last_step);
        go_idle   = 1'b0;
        restart   = 1'b0;
        advance   = 1'b0;
        if (state == IDLE) begin
            restart = start && !stop;
        end else begin
            go_idle = stop || (!start && song_end && !loop);
            restart = !stop && (start || (song_end && loop));
            advance = !stop && !start && !song_end && step_wrap;
        end
        if (restart)      addr_nxt = '0;
        else if (advance) addr_nxt = step_addr + 1'b1;
        else              addr_nxt = step_addr;
        tone_run = (state == PLAY) && !go_idle;
        gap_done = (step_cnt >= GAP_END);
    end

    // Control FSM: play state, step index, tempo counter, busy and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_addr <= '0;
            step_cnt  <= '0;
        end else begin
            done      <= 1'b0;
            step_addr <= addr_nxt;
            case (state)
                IDLE: begin
                    if (restart) begin
                        state    <= PLAY;
                        busy     <= 1'b1;
                        step_cnt <= '0;
                    end
                end
                PLAY: begin
                    if (go_idle) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        step_cnt <= '0;
                        done     <= !stop;
                    end else if (restart || advance) begin
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Song memory write port; a read of the same entry this cycle still sees the old code.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VOICES; v++) begin
            if (wr_en && (wr_voice == VW'(v))) mem[v][wr_addr] <= wr_data;
        end
    end

    // Song memory read port, addressed with the next step so note_q tracks step_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VOICES; v++) note_q[v] <= 6'd0;
        end else begin
            for (int v = 0; v < VOICES; v++) note_q[v] <= mem[v][addr_nxt];
        end
    end

    // Tone generators: cascaded note/octave dividers, toggle only after the articulation gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk <= '0;
            for (int v = 0; v < VOICES; v++) begin
                note_cnt[v] <= 9'd0;
                oct_cnt[v]  <= 8'd0;
            end
        end else if (!tone_run) begin
            spk <= '0;
            for (int v = 0; v < VOICES; v++) begin
                note_cnt[v] <= 9'd0;
                oct_cnt[v]  <= 8'd0;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (note_cnt[v] == 9'd0) begin
                    note_cnt[v] <= div_val[v];
                    if (oct_cnt[v] == 8'd0) begin
                        oct_cnt[v] <= oct_rld[v];
                        if (audible[v] && gap_done) spk[v] <= ~spk[v];
                    end else begin
                        oct_cnt[v] <= oct_cnt[v] - 1'b1;
                    end
                end else begin
                    note_cnt[v] <= note_cnt[v] - 1'b1;
                end
            end
        end
    end

    // Time-multiplexed mix: rotate through the voices one per clock onto the speaker pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= '0;
            spkp <= 1'b0;
        end else begin
            sel  <= (sel == VW'(VOICES - 1)) ? '0 : sel + 1'b1;
            spkp <= spk[sel];
        end
    end

    assign spkm = ~spkp;

endmodule

// File: tb/tb_tune_sequencer.sv
// Purpose: directed checks of tune_sequencer control, tone timing, mix and song-end handling.
// Latency: outputs sampled on the falling edge; the cycle counter counts rising edges since start.
// Backpressure: none; every wait is bounded and a timeout is reported as a failed check.
module tb_tune_sequencer;

    localparam int STEP = 5000;
    localparam int GAP  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic       wr_en = 1'b0;
    logic [0:0] wr_voice = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [5:0] wr_data = 6'd0;
    logic [1:0] spk;
    logic       spkp;
    logic       spkm;
    logic       busy;
    logic [2:0] step_addr;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    bit spk1_seen = 1'b0;

    tune_sequencer #(
        .VOICES(2), .ADDR_W(3), .STEP_CYCLES(STEP), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .wr_en(wr_en), .wr_voice(wr_voice), .wr_addr(wr_addr), .wr_data(wr_data),
        .spk(spk), .spkp(spkp), .spkm(spkm), .busy(busy),
        .step_addr(step_addr), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (spk[1] === 1'b1) spk1_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int v, input int a, input int d);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_voice = v[0:0];
        wr_addr  = a[2:0];
        wr_data  = d[5:0];
        @(negedge clk);
        wr_en    = 1'b0;
    endtask

    // t0 holds the rising-edge count of the edge that samples start.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_addr(input int a, input int bound, output bit ok);
        int n = 0;
        while (int'(step_addr) != a && n < bound) begin
            @(negedge clk);
            n++;
        end
        ok = (int'(step_addr) == a);
    endtask

    task automatic wait_spk0(input logic lvl, input int bound, output bit ok);
        int n = 0;
        while (spk[0] !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        ok = (spk[0] === lvl);
    endtask

    task automatic wait_done(input int bound, output bit ok);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        ok = (done === 1'b1);
    endtask

    initial begin
        bit ok;
        int n1;
        int ones;
        int bad;
        int ns;
        int seq [8];
        logic [2:0] prev;
        bit done_seen;
        bit busy_low;

        // 1: reset values, start held during reset is ignored
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_spk", spk, 0);
        chk("rst_spkp", spkp, 0);
        chk("rst_spkm", spkm, 1);
        chk("rst_busy", busy, 0);
        chk("rst_step_addr", step_addr, 0);
        chk("rst_done", done, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("start_in_reset_ignored", busy, 0);

        // 2/3: A in octave 5 over two steps, end code at step 2, loop off
        wr(0, 0, 60); wr(1, 0, 0);
        wr(0, 1, 60); wr(1, 1, 0);
        wr(0, 2, 63); wr(1, 2, 0);
        spk1_seen = 1'b0;
        loop = 1'b0;
        pulse_start();
        repeat (20) @(negedge clk);
        chk("gap_spk_quiet", spk, 0);
        chk("play_busy", busy, 1);
        wait_spk0(1'b1, 6000, ok);
        chk("first_toggle_seen", ok, 1);
        n1 = cyc - t0;
        chk("first_toggle_after_gap", (n1 > GAP && n1 <= 4097), 1);
        ones = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (spkp) ones++;
            if (spkm !== ~spkp) bad++;
        end
        chk("mix_ones_of_8", ones, 4);
        chk("spkm_is_not_spkp", bad, 0);
        wait_spk0(1'b0, 5000, ok);
        chk("second_toggle_seen", ok, 1);
        chk("half_period", (cyc - t0) - n1, 4096);
        wait_addr(2, 6000, ok);
        chk("reach_step2", ok, 1);
        chk("done_before_latency", done, 0);
        chk("busy_before_end", busy, 1);
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_fell", busy, 0);
        chk("spk_cleared_at_end", spk, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("spkp_after_end", spkp, 0);
        chk("spkm_after_end", spkm, 1);
        chk("step_addr_held", step_addr, 2);
        chk("voice1_rest_silent", spk1_seen, 0);

        // 4: end code at step 1 with loop on, then reset mid-playback
        wr(0, 1, 63);
        loop = 1'b1;
        pulse_start();
        ns = 0;
        done_seen = 1'b0;
        busy_low = 1'b0;
        prev = step_addr;
        for (int i = 0; i < 3 * (STEP + 1) + 50; i++) begin
            @(negedge clk);
            if (step_addr != prev && ns < 8) begin
                seq[ns] = int'(step_addr);
                ns++;
            end
            prev = step_addr;
            if (done) done_seen = 1'b1;
            if (!busy) busy_low = 1'b1;
        end
        chk("loop_changes", ns, 6);
        chk("loop_seq0", seq[0], 1);
        chk("loop_seq1", seq[1], 0);
        chk("loop_seq2", seq[2], 1);
        chk("loop_seq3", seq[3], 0);
        chk("loop_no_done", done_seen, 0);
        chk("loop_busy_held", busy_low, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_spk", spk, 0);
        chk("midrst_spkm", spkm, 1);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        loop = 1'b0;

        // 5: stop while a tone is high, then start and stop together
        pulse_start();
        repeat (4499) @(negedge clk);
        chk("tone_high_before_stop", spk, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_spk", spk, 0);
        @(negedge clk);
        chk("stop_spkp", spkp, 0);
        chk("stop_spkm", spkm, 1);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk("start_stop_idle", busy, 0);
        repeat (3) @(negedge clk);
        chk("start_stop_stays_idle", busy, 0);

        // 6: full song of eight steps; a live write to step 2 is heard at step 2
        for (int a = 0; a < 8; a++) begin
            wr(0, a, a + 1);
            wr(1, a, 0);
        end
        pulse_start();
        wait_addr(1, 6000, ok);
        chk("reach_step1", ok, 1);
        wr(0, 2, 63);
        wait_done(12000, ok);
        chk("live_write_done_seen", ok, 1);
        chk("live_write_end_time", cyc - t0, 2 * STEP + 1);
        chk("live_write_end_addr", step_addr, 2);
        wr(0, 2, 3);
        pulse_start();
        wait_done(8 * STEP + 100, ok);
        chk("wrap_done_seen", ok, 1);
        chk("wrap_end_time", cyc - t0, 8 * STEP);
        chk("wrap_end_addr", step_addr, 7);
        chk("wrap_end_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
